// File: rtl/sdmac_pkg.sv
// Shared types and constants for the SDMAC register bus-cycle decoder.
package sdmac_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    WAIT,
    ACK,
    WD,
    TERM
  } state_e;

  localparam logic [7:0] ADR_ST_DMA  = 8'h10;
  localparam logic [7:0] ADR_FLUSH   = 8'h14;
  localparam logic [7:0] ADR_CLR_INT = 8'h18;
  localparam logic [7:0] ADR_SP_DMA  = 8'h3C;

  localparam logic [7:0] WD_BASE_DEF = 8'h40;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bus_sync.sv
// Flop-chain synchroniser for an asynchronous active-low strobe; resets to
// the inactive (high) level.
module bus_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '1;
    else     sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/reg_cycle_decoder.sv
// Clocked SDMAC register decoder: one bus-cycle FSM per CPU access producing
// register strobes, action pulses, the WD33C93 window request and termination.
//
// state  | meaning
// IDLE   | waiting for a qualified AS_/DMAC_ access
// DECODE | address/direction latched, classifying the access
// WAIT   | strobe asserted, counting wait states before DSACK_
// ACK    | DSACK_ asserted, holding until AS_ is released
// WD     | SCSI window requested, waiting for WD_ACK or timeout
// TERM   | BERR_ asserted after window timeout, holding until AS_ release
module reg_cycle_decoder
  import sdmac_pkg::*;
#(
  parameter int                ADDR_W      = 8,
  parameter int                NUM_REGS    = 16,
  parameter logic [ADDR_W-1:0] WD_BASE     = ADDR_W'(WD_BASE_DEF),
  parameter int                WAIT_STATES = 1,
  parameter int                WD_TIMEOUT  = 63,
  parameter int                SYNC_STAGES = 2
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [ADDR_W-1:0]   ADDR,
  input  logic                AS_,
  input  logic                DMAC_,
  input  logic                RW,
  input  logic                DMADIR,
  input  logic                WD_ACK,
  output logic [NUM_REGS-1:0] REG_RD,
  output logic [NUM_REGS-1:0] REG_WR,
  output logic                ST_DMA,
  output logic                SP_DMA,
  output logic                CLR_INT,
  output logic                FLUSH,
  output logic                WDREGREQ,
  output logic                DSACK_,
  output logic                BERR_
);

  localparam int CNT_W  = $clog2(max2(WD_TIMEOUT, WAIT_STATES) + 1);
  localparam int FILL_W = $clog2(SYNC_STAGES + 1);
  localparam int IDX_W  = ADDR_W - 2;

  logic as_s;
  logic dmac_s;

  bus_sync #(.STAGES(SYNC_STAGES)) u_sync_as (
    .clk (CLK),
    .rst (RST),
    .d   (AS_),
    .q   (as_s)
  );

  bus_sync #(.STAGES(SYNC_STAGES)) u_sync_dmac (
    .clk (CLK),
    .rst (RST),
    .d   (DMAC_),
    .q   (dmac_s)
  );

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                rw_q, rw_d;
  logic                armed_q, armed_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [NUM_REGS-1:0] reg_rd_q, reg_rd_d;
  logic [NUM_REGS-1:0] reg_wr_q, reg_wr_d;
  logic                st_dma_q, st_dma_d;
  logic                sp_dma_q, sp_dma_d;
  logic                clr_int_q, clr_int_d;
  logic                flush_q, flush_d;
  logic                wdreq_q, wdreq_d;
  logic                dsack_n_q, dsack_n_d;
  logic                berr_n_q, berr_n_d;

  logic [IDX_W-1:0] idx;
  logic             fill_done;
  logic             valid;
  logic             go_idle;

  assign idx = addr_q[ADDR_W-1:2];
  // The synchroniser output only reflects a real AS_ sample once the chain
  // has refilled after reset; until then its reset "high" must not arm us.
  assign fill_done = (fill_q == FILL_W'(SYNC_STAGES));
  assign valid     = ~as_s & ~dmac_s & armed_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    rw_d      = rw_q;
    armed_d   = armed_q | (as_s & fill_done);
    fill_d    = fill_done ? fill_q : fill_q + FILL_W'(1);
    reg_rd_d  = reg_rd_q;
    reg_wr_d  = reg_wr_q;
    st_dma_d  = 1'b0;
    sp_dma_d  = 1'b0;
    clr_int_d = 1'b0;
    flush_d   = 1'b0;
    wdreq_d   = wdreq_q;
    dsack_n_d = dsack_n_q;
    berr_n_d  = berr_n_q;
    go_idle   = 1'b0;

    case (state_q)
      IDLE: begin
        if (valid) begin
          addr_d  = ADDR;
          rw_d    = RW;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (as_s) begin
          go_idle = 1'b1;
        end else if (addr_q >= WD_BASE) begin
          wdreq_d = 1'b1;
          cnt_d   = CNT_W'(WD_TIMEOUT - 1);
          state_d = WD;
        end else begin
          if (addr_q[1:0] == 2'b00 && 32'(idx) < NUM_REGS) begin
            if (rw_q) reg_rd_d = NUM_REGS'(1) << idx;
            else      reg_wr_d = NUM_REGS'(1) << idx;
          end
          st_dma_d  = (addr_q == ADDR_W'(ADR_ST_DMA));
          flush_d   = (addr_q == ADDR_W'(ADR_FLUSH)) & DMADIR;
          clr_int_d = (addr_q == ADDR_W'(ADR_CLR_INT));
          sp_dma_d  = (addr_q == ADDR_W'(ADR_SP_DMA));
          cnt_d     = CNT_W'(WAIT_STATES);
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (as_s) begin
          go_idle = 1'b1;
        end else if (cnt_q == '0) begin
          dsack_n_d = 1'b0;
          state_d   = ACK;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      WD: begin
        // Abort beats completion, and a late WD_ACK still beats the timeout.
        if (as_s) begin
          go_idle = 1'b1;
        end else if (WD_ACK) begin
          dsack_n_d = 1'b0;
          state_d   = ACK;
        end else if (cnt_q == '0) begin
          berr_n_d = 1'b0;
          wdreq_d  = 1'b0;
          state_d  = TERM;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ACK, TERM: begin
        if (as_s) go_idle = 1'b1;
      end
      default: begin
        go_idle = 1'b1;
      end
    endcase

    if (go_idle) begin
      state_d   = IDLE;
      cnt_d     = '0;
      reg_rd_d  = '0;
      reg_wr_d  = '0;
      wdreq_d   = 1'b0;
      dsack_n_d = 1'b1;
      berr_n_d  = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      rw_q      <= 1'b0;
      armed_q   <= 1'b0;
      fill_q    <= '0;
      reg_rd_q  <= '0;
      reg_wr_q  <= '0;
      st_dma_q  <= 1'b0;
      sp_dma_q  <= 1'b0;
      clr_int_q <= 1'b0;
      flush_q   <= 1'b0;
      wdreq_q   <= 1'b0;
      dsack_n_q <= 1'b1;
      berr_n_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      rw_q      <= rw_d;
      armed_q   <= armed_d;
      fill_q    <= fill_d;
      reg_rd_q  <= reg_rd_d;
      reg_wr_q  <= reg_wr_d;
      st_dma_q  <= st_dma_d;
      sp_dma_q  <= sp_dma_d;
      clr_int_q <= clr_int_d;
      flush_q   <= flush_d;
      wdreq_q   <= wdreq_d;
      dsack_n_q <= dsack_n_d;
      berr_n_q  <= berr_n_d;
    end
  end

  assign REG_RD   = reg_rd_q;
  assign REG_WR   = reg_wr_q;
  assign ST_DMA   = st_dma_q;
  assign SP_DMA   = sp_dma_q;
  assign CLR_INT  = clr_int_q;
  assign FLUSH    = flush_q;
  assign WDREGREQ = wdreq_q;
  assign DSACK_   = dsack_n_q;
  assign BERR_    = berr_n_q;

endmodule

// File: tb/tb_reg_cycle_decoder.sv
// Bench for reg_cycle_decoder: two parameterisations driven in parallel and
// checked cycle by cycle against a latency-rule model of each bus access.
module tb_reg_cycle_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] addr;
  logic       as_n, dmac_n, rw, dmadir, wd_ack;

  logic [15:0] a_rd, a_wr;
  logic        a_st, a_sp, a_clr, a_fl, a_wdreq, a_dsack_n, a_berr_n;
  logic [7:0]  b_rd, b_wr;
  logic        b_st, b_sp, b_clr, b_fl, b_wdreq, b_dsack_n, b_berr_n;

  reg_cycle_decoder dut_a (
    .CLK(clk), .RST(rst), .ADDR(addr), .AS_(as_n), .DMAC_(dmac_n), .RW(rw),
    .DMADIR(dmadir), .WD_ACK(wd_ack), .REG_RD(a_rd), .REG_WR(a_wr),
    .ST_DMA(a_st), .SP_DMA(a_sp), .CLR_INT(a_clr), .FLUSH(a_fl),
    .WDREGREQ(a_wdreq), .DSACK_(a_dsack_n), .BERR_(a_berr_n)
  );

  reg_cycle_decoder #(.NUM_REGS(8), .WAIT_STATES(5), .WD_TIMEOUT(20)) dut_b (
    .CLK(clk), .RST(rst), .ADDR(addr), .AS_(as_n), .DMAC_(dmac_n), .RW(rw),
    .DMADIR(dmadir), .WD_ACK(wd_ack), .REG_RD(b_rd), .REG_WR(b_wr),
    .ST_DMA(b_st), .SP_DMA(b_sp), .CLR_INT(b_clr), .FLUSH(b_fl),
    .WDREGREQ(b_wdreq), .DSACK_(b_dsack_n), .BERR_(b_berr_n)
  );

  typedef struct packed {
    logic [15:0] rd;
    logic [15:0] wr;
    logic [3:0]  pul;     // {ST_DMA, SP_DMA, CLR_INT, FLUSH}
    logic        wdreq;
    logic        dsack_n;
    logic        berr_n;
  } obs_t;

  int n_checks = 0;
  int n_errors = 0;

  // current access: selected, address, direction, DMADIR, AS_ release edge,
  // first edge WD_ACK is high (-1 = never)
  logic cur_sel;
  int   cur_addr;
  logic cur_rw, cur_dmadir;
  int   cur_r, cur_wa;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected outputs after edge t, AS_ first sampled low at edge 0.
  function automatic obs_t model(input int t, input int nr, input int w, input int to);
    obs_t o;
    int   fin, ea, tmo, idx;
    logic live;
    o = '0;
    o.dsack_n = 1'b1;
    o.berr_n  = 1'b1;
    if (!cur_sel) return o;
    fin  = cur_r + 2;
    live = (t >= 3) && (t < fin);
    if (cur_addr >= 'h40) begin
      tmo = 3 + to;
      ea  = (cur_wa < 4) ? 4 : cur_wa;
      if (cur_wa >= 0 && ea <= tmo && ea < fin) begin
        o.wdreq   = live;
        o.dsack_n = !(t >= ea && t < fin);
      end else if (tmo < fin) begin
        o.wdreq  = (t >= 3) && (t < tmo);
        o.berr_n = !(t >= tmo && t < fin);
      end else begin
        o.wdreq = live;
      end
    end else begin
      idx = cur_addr / 4;
      if (cur_addr % 4 == 0 && idx < nr && live) begin
        if (cur_rw) o.rd = 16'(1) << idx;
        else        o.wr = 16'(1) << idx;
      end
      o.dsack_n = !(t >= 4 + w && t < fin);
      if (t == 3)
        o.pul = {cur_addr == 'h10, cur_addr == 'h3C, cur_addr == 'h18,
                 (cur_addr == 'h14) && cur_dmadir};
    end
    return o;
  endfunction

  task automatic cmp(input string who, input int t, input obs_t got, input obs_t exp);
    chk($sformatf("%s.REG_RD@%0d a=%0h", who, t, cur_addr), 32'(got.rd), 32'(exp.rd));
    chk($sformatf("%s.REG_WR@%0d a=%0h", who, t, cur_addr), 32'(got.wr), 32'(exp.wr));
    chk($sformatf("%s.PULSE@%0d a=%0h", who, t, cur_addr), 32'(got.pul), 32'(exp.pul));
    chk($sformatf("%s.WDREGREQ@%0d a=%0h", who, t, cur_addr), 32'(got.wdreq), 32'(exp.wdreq));
    chk($sformatf("%s.DSACK_@%0d a=%0h", who, t, cur_addr), 32'(got.dsack_n), 32'(exp.dsack_n));
    chk($sformatf("%s.BERR_@%0d a=%0h", who, t, cur_addr), 32'(got.berr_n), 32'(exp.berr_n));
  endtask

  task automatic check_both(input int t);
    obs_t ga, gb;
    ga = '{rd: a_rd, wr: a_wr, pul: {a_st, a_sp, a_clr, a_fl},
           wdreq: a_wdreq, dsack_n: a_dsack_n, berr_n: a_berr_n};
    gb = '{rd: {8'h00, b_rd}, wr: {8'h00, b_wr}, pul: {b_st, b_sp, b_clr, b_fl},
           wdreq: b_wdreq, dsack_n: b_dsack_n, berr_n: b_berr_n};
    cmp("A", t, ga, model(t, 16, 1, 63));
    cmp("B", t, gb, model(t, 8, 5, 20));
  endtask

  task automatic run_access(input logic sel, input int a, input logic rw_i,
                            input logic dir, input int r, input int wa);
    cur_sel = sel; cur_addr = a; cur_rw = rw_i; cur_dmadir = dir;
    cur_r = r; cur_wa = wa;
    for (int t = 0; t <= r + 4; t++) begin
      @(negedge clk);
      addr   = 8'(a);
      rw     = rw_i;
      dmadir = dir;
      as_n   = (t < r) ? 1'b0 : 1'b1;
      dmac_n = (sel && t < r) ? 1'b0 : 1'b1;
      wd_ack = (wa >= 0 && t >= wa && t < r) ? 1'b1 : 1'b0;
      @(posedge clk);
      #1;
      check_both(t);
    end
    cur_sel = 1'b0;
  endtask

  task automatic idle_cycles(input int n, input logic as_v, input logic dmac_v);
    cur_sel = 1'b0;
    for (int t = 0; t < n; t++) begin
      @(negedge clk);
      as_n   = as_v;
      dmac_n = dmac_v;
      wd_ack = 1'b0;
      @(posedge clk);
      #1;
      check_both(t);
    end
  endtask

  // Reset while a cycle sits in ACK with AS_ still low.
  task automatic reset_mid_ack();
    cur_sel = 1'b1; cur_addr = 'h08; cur_rw = 1'b1; cur_dmadir = 1'b0;
    cur_r = 1000; cur_wa = -1;
    for (int t = 0; t <= 12; t++) begin
      @(negedge clk);
      addr = 8'h08; rw = 1'b1; dmadir = 1'b0;
      as_n = 1'b0; dmac_n = 1'b0; wd_ack = 1'b0;
      @(posedge clk);
      #1;
      check_both(t);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    cur_sel = 1'b0;
    check_both(100);
    @(negedge clk);
    rst = 1'b0;
    idle_cycles(10, 1'b0, 1'b0);
    idle_cycles(6, 1'b1, 1'b1);
  endtask

  initial begin
    int pick, a, r, wa;
    logic sel;
    rst = 1'b1; addr = '0; as_n = 1'b1; dmac_n = 1'b1;
    rw = 1'b0; dmadir = 1'b0; wd_ack = 1'b0;
    cur_sel = 1'b0; cur_addr = 0; cur_rw = 1'b0; cur_dmadir = 1'b0;
    cur_r = 0; cur_wa = -1;
    repeat (3) @(posedge clk);
    #1;
    check_both(-1);
    @(negedge clk);
    rst = 1'b0;
    idle_cycles(6, 1'b1, 1'b1);

    run_access(1'b1, 'h08, 1'b1, 1'b0, 10, -1);
    run_access(1'b1, 'h10, 1'b0, 1'b0, 10, -1);
    run_access(1'b1, 'h14, 1'b0, 1'b0, 10, -1);
    run_access(1'b1, 'h14, 1'b0, 1'b1, 10, -1);
    run_access(1'b1, 'h18, 1'b1, 1'b0, 8, -1);
    run_access(1'b1, 'h44, 1'b1, 1'b0, 80, 9);
    run_access(1'b1, 'h44, 1'b0, 1'b0, 80, -1);
    run_access(1'b1, 'h08, 1'b1, 1'b0, 5, -1);
    run_access(1'b1, 'h08, 1'b0, 1'b0, 2, -1);
    reset_mid_ack();
    run_access(1'b1, 'h02, 1'b1, 1'b0, 12, -1);
    run_access(1'b1, 'h3C, 1'b0, 1'b0, 12, -1);
    run_access(1'b1, 'h20, 1'b1, 1'b0, 12, -1);
    run_access(1'b0, 'h10, 1'b1, 1'b0, 8, -1);

    for (int i = 0; i < 60; i++) begin
      sel  = ($urandom_range(0, 9) != 0);
      pick = $urandom_range(0, 8);
      case (pick)
        0: a = 'h10;
        1: a = 'h14;
        2: a = 'h18;
        3: a = 'h3C;
        4: a = 'h40 + $urandom_range(0, 'hBF);
        5: a = 'h44;
        6: a = $urandom_range(0, 'h3F);
        default: a = 4 * $urandom_range(0, 15);
      endcase
      if (a >= 'h40) begin
        r  = $urandom_range(2, 90);
        wa = ($urandom_range(0, 2) != 0) ? $urandom_range(4, 80) : -1;
      end else begin
        r  = $urandom_range(2, 20);
        wa = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 10) : -1;
      end
      run_access(sel, a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), r, wa);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
